// File: rtl/game_flow_fsm.sv
// ---------------------------------------------------------------------------
// game_flow_fsm
//   Master game sequencer. Drives the counter bank (clear and enables), issues
//   the one-cycle score increment and explosion-load pulses, runs the recovery
//   window, and tracks remaining lives and the game-over condition.
//
// Ports
//   clk                   in   system clock
//   reset                 in   asynchronous, active-high reset
//   start                 in   single-cycle start request
//   collision             in   level: player overlaps an obstacle
//   startCycle            in   pulse: obstacle cycle period elapsed
//   explosionDone         in   level: explosion counter reached zero
//   recover               in   pulse: recover counter reached zero
//   timeUp                in   sticky level: game time expired
//   CounterClear          out  synchronous clear to all game counters
//   ChangeStateCounterEn  out  obstacle state-change reload enable
//   CycleWaitCounterEn    out  obstacle cycle reload enable
//   ScoreInc              out  registered one-cycle score increment
//   runOver               out  registered one-cycle explosion-counter load
//   StartRecover          out  recover-counter run enable
//   gameActive            out  high in RUN, HIT and RECOVER
//   gameOver              out  high in OVER
//   livesLeft             out  remaining lives
//   state                 out  current state code (debug / overlay)
// ---------------------------------------------------------------------------
module game_flow_fsm #(
    parameter int LIVES      = 3,
    parameter int LIVES_W    = 2,
    parameter int EXP_IGNORE = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               collision,
    input  logic               startCycle,
    input  logic               explosionDone,
    input  logic               recover,
    input  logic               timeUp,
    output logic               CounterClear,
    output logic               ChangeStateCounterEn,
    output logic               CycleWaitCounterEn,
    output logic               ScoreInc,
    output logic               runOver,
    output logic               StartRecover,
    output logic               gameActive,
    output logic               gameOver,
    output logic [LIVES_W-1:0] livesLeft,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_HIT     = 3'd3,
        S_RECOVER = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    // Wide enough to hold EXP_IGNORE; the counter saturates there.
    localparam int HC_W = $clog2(EXP_IGNORE + 1) + 1;
    localparam logic [HC_W-1:0]    HIT_THRESH = HC_W'(EXP_IGNORE);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] ONE_LIFE   = LIVES_W'(1);

    state_t              state_q, state_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic [HC_W-1:0]     hit_cnt_q, hit_cnt_d;   // cycles spent in HIT so far
    logic                rec_seen_q, rec_seen_d; // first recover pulse seen
    logic                score_inc_q, score_inc_d;
    logic                run_over_q, run_over_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lives_q     <= '0;
            hit_cnt_q   <= '0;
            rec_seen_q  <= 1'b0;
            score_inc_q <= 1'b0;
            run_over_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            hit_cnt_q   <= hit_cnt_d;
            rec_seen_q  <= rec_seen_d;
            score_inc_q <= score_inc_d;
            run_over_q  <= run_over_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        hit_cnt_d   = hit_cnt_q;
        rec_seen_d  = rec_seen_q;
        score_inc_d = 1'b0;
        run_over_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                // timeUp is still being cleared by CounterClear here, so it
                // is deliberately not looked at.
                lives_d = LIVES_INIT;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (timeUp) begin
                    state_d = S_OVER;
                end else if (collision) begin
                    state_d    = S_HIT;
                    hit_cnt_d  = '0;
                    run_over_d = 1'b1;   // lands in the first HIT cycle
                end else if (startCycle) begin
                    score_inc_d = 1'b1;
                end
            end
            S_HIT: begin
                if (timeUp) begin
                    state_d = S_OVER;
                end else if ((hit_cnt_q >= HIT_THRESH) && explosionDone) begin
                    // explosionDone may still be stale from before the load
                    // issued by runOver, hence the ignore window above.
                    if (lives_q <= ONE_LIFE) begin
                        lives_d = '0;
                        state_d = S_OVER;
                    end else begin
                        lives_d    = lives_q - ONE_LIFE;
                        rec_seen_d = 1'b0;
                        state_d    = S_RECOVER;
                    end
                end else if (hit_cnt_q < HIT_THRESH) begin
                    hit_cnt_d = hit_cnt_q + 1'b1;
                end
            end
            S_RECOVER: begin
                // Exiting on the second pulse guarantees at least one full
                // recover period of invulnerability; collision is ignored.
                if (timeUp) begin
                    state_d = S_OVER;
                end else if (recover) begin
                    if (rec_seen_q) state_d = S_RUN;
                    else            rec_seen_d = 1'b1;
                end
            end
            S_OVER: begin
                if (start) state_d = S_CLEAR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign CounterClear         = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign gameActive           = (state_q == S_RUN) || (state_q == S_HIT) ||
                                  (state_q == S_RECOVER);
    assign ChangeStateCounterEn = gameActive;
    assign CycleWaitCounterEn   = gameActive;
    assign StartRecover         = (state_q == S_RECOVER);
    assign gameOver             = (state_q == S_OVER);
    assign ScoreInc             = score_inc_q;
    assign runOver              = run_over_q;
    assign livesLeft            = lives_q;
    assign state                = state_q;

endmodule
